// File: rtl/fir_pkg.sv
// Shared types and width helpers for the DA FIR core.
// Holds the FSM encoding and the output width derivation.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int out_width(input int dw, input int cw, input int taps);
        return dw + cw + clog2(taps);
    endfunction

endpackage

// File: rtl/fir_da_lut.sv
// One DA partition: masked sum of LUT_IN signed coefficients.
// Purely combinational; the select is one bit-slice of the delay line.
module fir_da_lut
    import fir_pkg::*;
#(
    parameter int LUT_IN = 4,
    parameter int COEF_W = 16
) (
    input  logic [LUT_IN-1:0]                    sel,
    input  logic [LUT_IN-1:0][COEF_W-1:0]        coef,
    output logic signed [COEF_W+clog2(LUT_IN)-1:0] psum
);

    localparam int SUM_W = COEF_W + clog2(LUT_IN);

    // add the sign-extended coefficients whose select bit is set
    always_comb begin
        psum = '0;
        for (int i = 0; i < LUT_IN; i++) begin
            if (sel[i]) psum = psum + SUM_W'($signed(coef[i]));
        end
    end

endmodule

// File: rtl/fir_da_param.sv
// Bit-serial distributed-arithmetic FIR with loadable coefficients.
// One sample per handshake, MSB-first, full-precision result.
module fir_da_param
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 16,
    parameter int LUT_IN = 4,
    parameter int OUT_W  = out_width(DATA_W, COEF_W, TAPS)
) (
    input  logic                     clk,
    input  logic                     areset_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     coef_we,
    input  logic [clog2(TAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    input  logic                     clear,
    output logic                     busy
);

    localparam int NPART = TAPS / LUT_IN;
    localparam int CW    = (clog2(DATA_W) < 1) ? 1 : clog2(DATA_W);
    localparam int SUM_W = COEF_W + clog2(LUT_IN);
    localparam int P_W   = COEF_W + clog2(TAPS);

    state_t state_q, state_d;

    logic [TAPS-1:0][DATA_W-1:0] x_q;
    logic [TAPS-1:0][COEF_W-1:0] coef_q;
    logic [CW-1:0]               cnt_q;
    logic signed [OUT_W-1:0]     acc_q;

    logic                        accept;
    logic                        coef_ok;
    logic                        clr_ok;
    logic                        finish;
    logic                        release_out;

    logic [TAPS-1:0]             bsel;
    logic signed [SUM_W-1:0]     psum [NPART];
    logic signed [P_W-1:0]       p_sum;
    logic signed [OUT_W-1:0]     p_ext;
    logic signed [OUT_W-1:0]     acc_next;
    logic                        first;

    assign busy = (state_q != IDLE);

    // gather bit cnt of every tap into the DA select vector
    always_comb begin
        bsel = '0;
        for (int k = 0; k < TAPS; k++) begin
            bsel[k] = x_q[k][cnt_q];
        end
    end

    for (genvar g = 0; g < NPART; g++) begin : g_part
        fir_da_lut #(
            .LUT_IN (LUT_IN),
            .COEF_W (COEF_W)
        ) u_lut (
            .sel  (bsel[g*LUT_IN +: LUT_IN]),
            .coef (coef_q[g*LUT_IN +: LUT_IN]),
            .psum (psum[g])
        );
    end

    // sum partitions; sign bit is subtracted, others shift-and-add
    always_comb begin
        p_sum = '0;
        for (int g = 0; g < NPART; g++) begin
            p_sum = p_sum + P_W'(psum[g]);
        end
        p_ext    = OUT_W'(p_sum);
        first    = (cnt_q == CW'(DATA_W - 1));
        acc_next = first ? -p_ext : (acc_q <<< 1) + p_ext;
    end

    // state register
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // next state and handshake/control decode
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        accept      = 1'b0;
        coef_ok     = 1'b0;
        clr_ok      = 1'b0;
        finish      = 1'b0;
        release_out = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                coef_ok  = coef_we;
                clr_ok   = clear;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    finish  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                in_ready = out_ready;
                if (out_ready) begin
                    release_out = 1'b1;
                    accept      = in_valid;
                    state_d     = in_valid ? CALC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // delay line: optional clear, then shift in the accepted sample
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            x_q <= '0;
        end else if (accept) begin
            if (clr_ok) begin
                x_q    <= '0;
                x_q[0] <= in_data;
            end else begin
                x_q <= {x_q[TAPS-2:0], in_data};
            end
        end else if (clr_ok) begin
            x_q <= '0;
        end
    end

    // coefficient bank, writable only while idle
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            coef_q <= '0;
        end else if (coef_ok) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    // bit counter and accumulator
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (accept) begin
            cnt_q <= CW'(DATA_W - 1);
            acc_q <= '0;
        end else if (state_q == CALC) begin
            acc_q <= acc_next;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
    end

    // output register, held until the downstream handshake
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (finish) begin
            out_data  <= acc_next;
            out_valid <= 1'b1;
        end else if (release_out) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_da_param.sv
// Scoreboard bench for fir_da_param (16 taps, 16x16 bit).
// Expected outputs come from a reference dot-product model.
module tb_fir_da_param;

    logic               clk;
    logic               areset_n;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [35:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               coef_we;
    logic [3:0]         coef_addr;
    logic [15:0]        coef_data;
    logic               clear;
    logic               busy;

    fir_da_param dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .clear     (clear),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;
    int n_out = 0;
    logic signed [63:0] last_out = '0;

    longint mc [16];
    longint mx [16];
    longint sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every output handshake pops one expected value
    always @(negedge clk) begin
        logic signed [63:0] obs;
        longint exp_v;
        if (areset_n && out_valid && out_ready) begin
            n_out++;
            total++;
            obs = out_data;
            last_out = obs;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got %0d, required no output", obs);
            end else begin
                exp_v = sb.pop_front();
                if (obs !== 64'(exp_v)) begin
                    bad++;
                    $display("FAIL sb_out: got %0d, required %0d", obs, exp_v);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic longint model_y();
        longint s;
        s = 0;
        for (int k = 0; k < 16; k++) s += mc[k] * mx[k];
        return s;
    endfunction

    task automatic model_accept(input logic signed [15:0] d, input bit clr);
        if (clr) for (int k = 0; k < 16; k++) mx[k] = 0;
        for (int k = 15; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = d;
        sb.push_back(model_y());
    endtask

    task automatic send(input logic signed [15:0] d, input bit clr);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        clear    = clr;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
        end else begin
            model_accept(d, clr);
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic write_coef(input int a, input logic signed [15:0] v, input bit upd);
        coef_we   = 1'b1;
        coef_addr = 4'(a);
        coef_data = v;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        if (upd) mc[a] = v;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        for (int k = 0; k < 16; k++) mx[k] = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_out_valid: got %b, required 0", out_valid);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy: got %b, required 0", busy);
        end
        areset_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_in_ready: got %b, required 1", in_ready);
        end
        total++;
        if (out_data !== 36'sd0) begin
            bad++;
            $display("FAIL rst_out_data: got %0d, required 0", out_data);
        end
    endtask

    task automatic test_impulse();
        int n;
        int a2;
        for (int k = 0; k < 16; k++) write_coef(k, 16'(k + 1), 1'b1);
        send(16'sd1, 1'b0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL latency: got %0d cycles, required 16", n);
        end
        send(16'sd0, 1'b0);
        a2 = last_acc;
        send(16'sd0, 1'b0);
        total++;
        if (last_acc - a2 != 17) begin
            bad++;
            $display("FAIL throughput: got %0d cycles, required 17", last_acc - a2);
        end
        for (int i = 0; i < 14; i++) send(16'sd0, 1'b0);
        drain();
        total++;
        if (last_out !== 64'sd0) begin
            bad++;
            $display("FAIL impulse_tail: got %0d, required 0", last_out);
        end
    endtask

    task automatic test_sign_extremes();
        write_coef(0, 16'sd32767, 1'b1);
        for (int k = 1; k < 16; k++) write_coef(k, 16'sd0, 1'b1);
        send(-16'sd32768, 1'b1);
        drain();
        total++;
        if (last_out !== -64'sd1073709056) begin
            bad++;
            $display("FAIL sign_neg: got %0d, required -1073709056", last_out);
        end
        send(16'sd32767, 1'b0);
        drain();
        total++;
        if (last_out !== 64'sd1073676289) begin
            bad++;
            $display("FAIL sign_pos: got %0d, required 1073676289", last_out);
        end
    endtask

    task automatic test_full_scale();
        for (int k = 0; k < 16; k++) write_coef(k, -16'sd32768, 1'b1);
        do_clear();
        for (int i = 0; i < 16; i++) send(-16'sd32768, 1'b0);
        drain();
        total++;
        if (last_out !== 64'sd17179869184) begin
            bad++;
            $display("FAIL full_scale: got %0d, required 17179869184", last_out);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic signed [35:0] held;
        out_ready = 1'b0;
        send(16'sd1234, 1'b0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (!out_valid) begin
            bad++;
            $display("FAIL bp_valid: got %b, required 1", out_valid);
        end
        held     = out_data;
        in_data  = -16'sd5;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held) begin
                bad++;
                $display("FAIL bp_hold: valid=%b ready=%b data=%0d, required 1 0 %0d",
                         out_valid, in_ready, out_data, held);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready: got %b, required 1", in_ready);
        end
        model_accept(-16'sd5, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_accept: valid=%b busy=%b, required 0 1", out_valid, busy);
        end
        drain();
    endtask

    task automatic test_coef_busy();
        write_coef(0, 16'sd3, 1'b1);
        do_clear();
        send(16'sd2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL coef_busy_state: got %b, required 1", busy);
        end
        write_coef(0, 16'sd100, 1'b0);
        send(16'sd1, 1'b0);
        drain();
        write_coef(0, 16'sd100, 1'b1);
        do_clear();
        send(16'sd1, 1'b0);
        drain();
        total++;
        if (last_out !== 64'sd100) begin
            bad++;
            $display("FAIL coef_idle_write: got %0d, required 100", last_out);
        end
        send(16'sd0, 1'b0);
        drain();
        total++;
        if (last_out !== -64'sd32768) begin
            bad++;
            $display("FAIL clear_history: got %0d, required -32768", last_out);
        end
    endtask

    task automatic test_reset_mid_calc();
        int seen;
        send(16'sd7, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        areset_n = 1'b0;
        sb.delete();
        for (int k = 0; k < 16; k++) begin
            mc[k] = 0;
            mx[k] = 0;
        end
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        areset_n = 1'b1;
        seen = n_out;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (n_out != seen) begin
            bad++;
            $display("FAIL midrst_partial: got %0d outputs, required 0", n_out - seen);
        end
        send(16'sd5, 1'b0);
        drain();
        total++;
        if (last_out !== 64'sd0) begin
            bad++;
            $display("FAIL midrst_coefs: got %0d, required 0", last_out);
        end
    endtask

    initial begin
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        clear     = 1'b0;
        areset_n  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            mc[k] = 0;
            mx[k] = 0;
        end
        #1;
        test_reset();
        test_impulse();
        test_sign_extremes();
        test_full_scale();
        test_backpressure();
        test_coef_busy();
        test_reset_mid_calc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_da_param.md
Name: fir_da_param

Overview:
Parametrised single-clock distributed-arithmetic (DA) FIR core. It is the successor to the fixed 64-tap/16-bit DA core, generalised in tap count, data width and coefficient width. It adds runtime-loadable coefficients, valid/ready handshakes on input and output, and a synchronous delay-line clear. It sits downstream of the input FIFO: it consumes one sample per handshake and emits one full-precision filtered sample per accepted input.

Parameters:
DATA_W, 16, sample width (signed two's complement)
COEF_W, 16, coefficient width (signed)
TAPS, 16, number of taps; must be a multiple of LUT_IN, at least 4
LUT_IN, 4, taps per DA partial-sum partition
OUT_W, DATA_W+COEF_W+clog2(TAPS), output width (derived; do not override)

Ports:
clk  in  1  single clock, rising edge
areset_n  in  1  asynchronous reset, active low
in_data  in  DATA_W  input sample
in_valid  in  1  in_data valid
in_ready  out  1  core can accept a sample
out_data  out  OUT_W  filtered result, signed
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(TAPS)  coefficient index (tap k)
coef_data  in  COEF_W  coefficient value
clear  in  1  zero the sample delay line (honoured in IDLE only)
busy  out  1  state is not IDLE

Behaviour:
- Reset (areset_n=0, asynchronous):
  - state=IDLE; delay line x[0..TAPS-1]=0; coefficients c[0..TAPS-1]=0; accumulator=0.
  - Outputs: out_data=0, out_valid=0, busy=0, in_ready=1 immediately after deassertion.
- Filter equation: y = sum over k of c[k]*x[k]. x[0] is the newest sample. Result is exact; no rounding or saturation.
- States: IDLE, CALC, HOLD.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&in_ready: x[k]<=x[k-1] for k>=1, x[0]<=in_data, bit counter <=DATA_W-1, accumulator <=0, go to CALC.
  - If coef_we is also asserted in the same cycle, the write applies first; the new coefficient is used for this sample.
- CALC: one cycle per sample bit, MSB first, DATA_W cycles total.
  - Bit vector b = bit[cnt] of every x[k].
  - Each LUT_IN-tap partition produces the sum of c[k] for which b[k]=1. The partition sums are added to give P.
  - First cycle (sign bit): acc <= -P. Following cycles: acc <= 2*acc + P.
  - When cnt reaches 0: out_data <= final acc, out_valid <= 1, go to HOLD.
- HOLD: out_data and out_valid are stable until out_ready=1.
  - On the handshake cycle: out_valid <= 0. If in_valid is also high, the new sample is accepted in that same cycle (in_ready = out_ready in HOLD) and the state goes to CALC; otherwise it goes to IDLE.
- Latency: sample accepted at edge N gives out_valid=1 after edge N+DATA_W.
- Throughput: one sample per DATA_W+1 cycles with out_ready tied high.
- in_ready is 0 throughout CALC.
- coef_we: honoured in IDLE only. It is silently ignored in CALC and HOLD, so the coefficient set is stable per sample.
- clear: honoured in IDLE only; zeroes x[*] and does not touch coefficients. If clear and an input accept occur together, the delay line is cleared and then the sample is shifted in, so only x[0]=in_data is nonzero.
- busy = (state != IDLE).
- Asserting areset_n mid-CALC aborts the computation. out_valid=0 and no partial result is ever presented.
- Arithmetic: partition sums are COEF_W+clog2(LUT_IN) bits. The accumulator is OUT_W bits, signed, with sign extension throughout. Full-scale worst case (all -2^(DATA_W-1) times -2^(COEF_W-1)) fits without overflow.

Decomposition:
- Shared package fir_pkg holds:
  - state encoding constants (IDLE/CALC/HOLD);
  - a clog2 constant function;
  - the OUT_W derivation.
- One sub-module, fir_da_lut: parameter LUT_IN and COEF_W. Inputs are a LUT_IN-bit select and LUT_IN coefficients; output is their masked sum (combinational). It is instantiated TAPS/LUT_IN times via generate.
- The top level holds the delay line, coefficient registers, FSM, counter and accumulator.

Test Plan:
- Impulse: load c[k]=k+1 (k=0..15); feed 1 then fifteen 0s, then one more 0 -> outputs 1,2,...,16 then 0. Each out_valid comes 16 cycles after its accept.
- Sign extremes: c[0]=32767, others 0; feed -32768 -> out_data = -1073709056. Then feed 32767 -> out_data = 1073676289.
- Full scale: all c=-32768; feed sixteen samples of -32768 -> 16th output = 17179869184. No wrap in the 36-bit result.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, a pending in_valid is not accepted. Release -> the new sample is accepted in the out_ready cycle.
- Coef write while busy: in CALC write c[0]=100 -> ignored, current and next result use the old c[0]. Write in IDLE -> takes effect on the next sample. Clear in IDLE -> following impulse response starts from zero history.
- Reset mid-CALC: drop areset_n at CALC cycle 5 -> out_valid=0, busy=0, all coefficients 0. A subsequent sample gives out_data=0.
